blk_mem_gen: RTL and testbench

Single-clock true dual-port block RAM with registered outputs and a built-in zero-clear sequence started by reset. It is the storage primitive for the hit-bookkeeping memories (hits-new, hits-count, hits-list); each of those is one instance with its own width and depth parameters. Both ports are fully symmetric: each can read or write any row in every cycle.

---
 rtl/blk_mem_gen.sv | 119 +++++++++++
 tb/tb_blk_mem_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/blk_mem_gen.sv
// Single-clock true dual-port RAM with read-first registered outputs and a
// reset-triggered zero-clear sequence that sweeps two rows per cycle.
module blk_mem_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  ena,
  input  logic                  enb,
  input  logic                  wea,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] douta,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // Pointer value of the final clear pair (rows DEPTH-2 and DEPTH-1).
  localparam logic [ADDR_WIDTH-1:0] LastPair = ADDR_WIDTH'(DEPTH - 2);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReset = 2'd1,
    StClear = 2'd2
  } state_e;

  // Power-up values model the configured device: zeroed array, ready high.
  state_e                  r_state = StIdle;
  logic [ADDR_WIDTH-1:0]   r_ptr   = '0;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0]   r_douta = '0;
  logic [DATA_WIDTH-1:0]   r_doutb = '0;

  state_e                  w_state_next;
  logic [ADDR_WIDTH-1:0]   w_ptr_next;
  logic                    w_user_ok;
  logic                    w_clear_wr;
  logic                    w_we_a;
  logic                    w_we_b;
  logic [ADDR_WIDTH-1:0]   w_addr_a;
  logic [ADDR_WIDTH-1:0]   w_addr_b;
  logic [DATA_WIDTH-1:0]   w_din_a;
  logic [DATA_WIDTH-1:0]   w_din_b;

  // User ops only in IDLE and never on an edge that samples reset.
  assign w_user_ok  = (r_state == StIdle) && !reset;
  // Clearing starts on the very first edge that samples reset low.
  assign w_clear_wr = (r_state != StIdle) && !reset;

  // Next-state and clear pointer sequencing; reset overrides every state.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      StReset, StClear: begin
        w_ptr_next   = r_ptr + ADDR_WIDTH'(2);
        w_state_next = (r_ptr == LastPair) ? StIdle : StClear;
      end
      default: begin
        w_state_next = r_state;
      end
    endcase
    if (reset) begin
      w_state_next = StReset;
      w_ptr_next   = '0;
    end
  end

  // State and clear pointer registers.
  always_ff @(posedge clock) begin
    r_state <= w_state_next;
    r_ptr   <= w_ptr_next;
  end

  // Array port muxing: the clear sequence owns both ports while it runs.
  always_comb begin
    w_we_a   = w_user_ok && ena && wea;
    w_we_b   = w_user_ok && enb && web;
    w_addr_a = addra;
    w_addr_b = addrb;
    w_din_a  = dina;
    w_din_b  = dinb;
    if (w_clear_wr) begin
      w_we_a   = 1'b1;
      w_we_b   = 1'b1;
      w_addr_a = r_ptr;
      w_addr_b = r_ptr | ADDR_WIDTH'(1);
      w_din_a  = '0;
      w_din_b  = '0;
    end
  end

  // Array writes; port A is applied last so it wins a same-row collision.
  always_ff @(posedge clock) begin
    if (w_we_b) r_mem[w_addr_b] <= w_din_b;
    if (w_we_a) r_mem[w_addr_a] <= w_din_a;
  end

  // Read-first output registers, forced to zero outside IDLE.
  always_ff @(posedge clock) begin
    if (reset || (r_state != StIdle)) begin
      r_douta <= '0;
      r_doutb <= '0;
    end else begin
      if (ena) r_douta <= r_mem[addra];
      if (enb) r_doutb <= r_mem[addrb];
    end
  end

  assign ready = (r_state == StIdle);
  assign douta = r_douta;
  assign doutb = r_doutb;

endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed bench for blk_mem_gen at default sizing (16 x 256).
module tb_blk_mem_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ready;
  logic        ena = 1'b0, enb = 1'b0, wea = 1'b0, web = 1'b0;
  logic [7:0]  addra = '0, addrb = '0;
  logic [15:0] dina = '0, dinb = '0;
  logic [15:0] douta, doutb;

  int nchk = 0;
  int nerr = 0;
  int cnt;

  blk_mem_gen #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .ready (ready),
    .ena   (ena),
    .enb   (enb),
    .wea   (wea),
    .web   (web),
    .addra (addra),
    .addrb (addrb),
    .dina  (dina),
    .dinb  (dinb),
    .douta (douta),
    .doutb (doutb)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_ports();
    ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [15:0] d);
    ena = 1'b1; wea = 1'b1; addra = a; dina = d;
    step();
    idle_ports();
  endtask

  task automatic rd2(input logic [7:0] a, input logic [7:0] b);
    ena = 1'b1; enb = 1'b1; wea = 1'b0; web = 1'b0; addra = a; addrb = b;
    step();
    idle_ports();
  endtask

  // Count samples with ready low, bounded so a stuck clear cannot hang.
  task automatic count_clear(output int n);
    n = 0;
    while (ready === 1'b0 && n < 300) begin
      n++;
      step();
    end
  endtask

  initial begin
    #1;
    chk("config_ready", 32'(ready), 32'd1);

    // Reset two cycles then release.
    reset = 1'b1;
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_douta", 32'(douta), 32'd0);
    chk("rst_doutb", 32'(doutb), 32'd0);
    step();
    reset = 1'b0;
    count_clear(cnt);
    chk("clear_len", 32'(cnt), 32'd128);
    chk("ready_after_clear", 32'(ready), 32'd1);

    rd2(8'd0, 8'd1);
    chk("rd_row0", 32'(douta), 32'd0);
    chk("rd_row1", 32'(doutb), 32'd0);
    rd2(8'd254, 8'd255);
    chk("rd_row254", 32'(douta), 32'd0);
    chk("rd_row255", 32'(doutb), 32'd0);

    // Write A then read B next cycle.
    wr_a(8'h05, 16'hBEEF);
    rd2(8'h00, 8'h05);
    chk("wr_then_rd_b", 32'(doutb), 32'hBEEF);

    // Read-first on both ports against an A write.
    wr_a(8'h10, 16'h0001);
    ena = 1'b1; wea = 1'b1; addra = 8'h10; dina = 16'h1234;
    enb = 1'b1; web = 1'b0; addrb = 8'h10;
    step();
    idle_ports();
    chk("rf_doutb_old", 32'(doutb), 32'h0001);
    chk("rf_douta_old", 32'(douta), 32'h0001);
    rd2(8'h10, 8'h10);
    chk("rf_new_a", 32'(douta), 32'h1234);
    chk("rf_new_b", 32'(doutb), 32'h1234);

    // Write collision: A data wins, both outputs return old content.
    ena = 1'b1; wea = 1'b1; addra = 8'h20; dina = 16'hAAAA;
    enb = 1'b1; web = 1'b1; addrb = 8'h20; dinb = 16'h5555;
    step();
    idle_ports();
    chk("coll_old_a", 32'(douta), 32'h0000);
    chk("coll_old_b", 32'(doutb), 32'h0000);
    rd2(8'h20, 8'h20);
    chk("coll_a", 32'(douta), 32'hAAAA);
    chk("coll_b", 32'(doutb), 32'hAAAA);

    // Port B write, read back on A.
    enb = 1'b1; web = 1'b1; addrb = 8'h30; dinb = 16'h0BBB;
    step();
    idle_ports();
    rd2(8'h30, 8'h05);
    chk("wr_b_rd_a", 32'(douta), 32'h0BBB);
    chk("rd_b_05", 32'(doutb), 32'hBEEF);

    // Enable gating: outputs hold, disabled writes do nothing.
    wr_a(8'd3, 16'h00FF);
    rd2(8'd3, 8'h10);
    chk("en_rd3", 32'(douta), 32'h00FF);
    ena = 1'b0; enb = 1'b0; addra = 8'd4; addrb = 8'd5;
    step();
    chk("en_hold_a", 32'(douta), 32'h00FF);
    chk("en_hold_b", 32'(doutb), 32'h1234);
    ena = 1'b0; wea = 1'b1; addra = 8'd3; dina = 16'hDEAD;
    enb = 1'b0; web = 1'b1; addrb = 8'd3; dinb = 16'hDEAD;
    step();
    idle_ports();
    chk("dis_wr_hold", 32'(douta), 32'h00FF);
    rd2(8'd3, 8'd3);
    chk("dis_wr_a", 32'(douta), 32'h00FF);
    chk("dis_wr_b", 32'(doutb), 32'h00FF);

    // Fill every row with row+1.
    for (int i = 0; i < 128; i++) begin
      ena = 1'b1; wea = 1'b1; addra = 8'(2 * i); dina = 16'(2 * i + 1);
      enb = 1'b1; web = 1'b1; addrb = 8'(2 * i + 1); dinb = 16'(2 * i + 2);
      step();
    end
    idle_ports();
    rd2(8'd7, 8'd255);
    chk("fill_row7", 32'(douta), 32'h0008);
    chk("fill_row255", 32'(doutb), 32'h0100);

    // Reset, let 40 clear cycles run with user writes attempted, then restart.
    reset = 1'b1;
    step();
    chk("rst2_douta", 32'(douta), 32'd0);
    chk("rst2_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    ena = 1'b1; wea = 1'b1; addra = 8'd200; dina = 16'hFFFF;
    enb = 1'b1; web = 1'b1; addrb = 8'd201; dinb = 16'hFFFF;
    for (int i = 0; i < 40; i++) step();
    chk("mid_clear_ready", 32'(ready), 32'd0);
    chk("mid_clear_douta", 32'(douta), 32'd0);
    chk("mid_clear_doutb", 32'(doutb), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    addra = 8'h80; addrb = 8'h81;
    count_clear(cnt);
    idle_ports();
    chk("restart_clear_len", 32'(cnt), 32'd128);
    chk("restart_douta", 32'(douta), 32'd0);

    for (int i = 0; i < 128; i++) begin
      rd2(8'(2 * i), 8'(2 * i + 1));
      chk($sformatf("cleared_a_%0d", 2 * i), 32'(douta), 32'd0);
      chk($sformatf("cleared_b_%0d", 2 * i + 1), 32'(doutb), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
